// File: rtl/lsu_dtcm_master.sv
// -----------------------------------------------------------------------------
// lsu_dtcm_master
//
// LSU-side initiator for the DTCM command/response interface. Accepts a single
// load/store from the EXU AGU, issues one word-aligned DTCM command with a byte
// write mask and lane-replicated write data, waits for the DTCM response and
// returns sign/zero-extended load data (or a store completion) on the
// writeback handshake. Only one transaction is ever outstanding.
//
// Configuration macro:
//   LSU_MISALIGN_CHK_EN  defined   : misaligned requests skip the DTCM and
//                                    complete immediately with lsu_wb_err = 1.
//                        undefined : lsu_wb_err is tied to 0; misaligned
//                                    address low bits are cleared and the
//                                    access proceeds as an aligned one.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   agu_req_*             request from the AGU (valid/ready handshake)
//   lsu_wb_*              completion towards writeback (valid/ready)
//   lsu2dtcm_cmd_*        DTCM command channel (valid/ready)
//   lsu2dtcm_rsp_*        DTCM response channel (valid/ready)
// -----------------------------------------------------------------------------
module lsu_dtcm_master #(
  parameter int DTCM_AW = 16,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               agu_req_valid,
  output logic               agu_req_ready,
  input  logic               agu_req_read,
  input  logic [31:0]        agu_req_addr,
  input  logic [1:0]         agu_req_size,
  input  logic               agu_req_usign,
  input  logic [DW-1:0]      agu_req_wdata,
  input  logic [4:0]         agu_req_rd,

  output logic               lsu_wb_valid,
  input  logic               lsu_wb_ready,
  output logic [DW-1:0]      lsu_wb_data,
  output logic [4:0]         lsu_wb_rd,
  output logic               lsu_wb_err,

  output logic               lsu2dtcm_cmd_valid,
  input  logic               lsu2dtcm_cmd_ready,
  output logic               lsu2dtcm_cmd_read,
  output logic [DTCM_AW-1:0] lsu2dtcm_cmd_addr,
  output logic [DW/8-1:0]    lsu2dtcm_cmd_wmask,
  output logic [DW-1:0]      lsu2dtcm_cmd_wdata,

  input  logic               lsu2dtcm_rsp_valid,
  output logic               lsu2dtcm_rsp_ready,
  input  logic [DW-1:0]      lsu2dtcm_rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_t               state_q, state_d;

  logic                 read_q;
  logic [DTCM_AW-1:0]   addr_q;
  logic [1:0]           size_q;
  logic                 usign_q;
  logic [DW-1:0]        wdata_q;
  logic [4:0]           rd_q;
  logic [DW-1:0]        wb_data_q;

  // Only the DTCM window of the address is meaningful here.
  logic                 unused_addr_hi;
  assign unused_addr_hi = ^agu_req_addr[31:DTCM_AW];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                 req_misalign;
  logic                 req_fire;
  logic                 req_skip;      // request bypasses the DTCM entirely
  logic [DTCM_AW-1:0]   req_addr;

  assign req_fire     = (state_q == IDLE) && agu_req_valid;
  // Size 2'b11 behaves like a word, so any size with bit 1 set is a word.
  assign req_misalign = ((agu_req_size == SZ_HALF) && agu_req_addr[0]) ||
                        (agu_req_size[1] && (agu_req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_CHK_EN
  assign req_skip = req_misalign;
  assign req_addr = agu_req_addr[DTCM_AW-1:0];
`else
  assign req_skip = 1'b0;

  // Without the checker, misaligned halves/words are silently aligned down;
  // clearing the bits also keeps the lane selection used on the response in
  // step with the address actually sent.
  always_comb begin
    req_addr = agu_req_addr[DTCM_AW-1:0];
    if (agu_req_size == SZ_HALF) req_addr[0]   = 1'b0;
    else if (agu_req_size[1])    req_addr[1:0] = 2'b00;
  end
`endif

  // ---------------------------------------------------------------------------
  // State register and next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is assigned a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (agu_req_valid)      state_d = req_skip ? WB : CMD;
      CMD:  if (lsu2dtcm_cmd_ready) state_d = RSP;
      RSP:  if (lsu2dtcm_rsp_valid) state_d = WB;
      WB:   if (lsu_wb_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request field registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      usign_q <= 1'b0;
      wdata_q <= '0;
      rd_q    <= 5'd0;
    end else if (req_fire) begin
      read_q  <= agu_req_read;
      addr_q  <= req_addr;
      size_q  <= agu_req_size;
      usign_q <= agu_req_usign;
      wdata_q <= agu_req_wdata;
      rd_q    <= agu_req_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting: pick the addressed lane, then extend
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rsp_shifted;
  logic [DW-1:0] load_data;

  always_comb begin
    rsp_shifted = lsu2dtcm_rsp_rdata;
    load_data   = lsu2dtcm_rsp_rdata;
    if (size_q == SZ_BYTE) begin
      rsp_shifted = lsu2dtcm_rsp_rdata >> {addr_q[1:0], 3'b000};
      load_data   = {{24{~usign_q & rsp_shifted[7]}}, rsp_shifted[7:0]};
    end else if (size_q == SZ_HALF) begin
      rsp_shifted = lsu2dtcm_rsp_rdata >> {addr_q[1], 4'b0000};
      load_data   = {{16{~usign_q & rsp_shifted[15]}}, rsp_shifted[15:0]};
    end
  end

  // Writeback data register: zero for stores and for skipped (erroring)
  // requests; cleared on every new request so a skipped one never shows
  // stale data.
  always_ff @(posedge clk) begin
    if (!rst_n)                                         wb_data_q <= '0;
    else if (req_fire)                                  wb_data_q <= '0;
    else if ((state_q == RSP) && lsu2dtcm_rsp_valid)    wb_data_q <= read_q ? load_data : '0;
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (req_fire) err_q <= req_misalign;
  end

  assign lsu_wb_err = err_q;
`else
  assign lsu_wb_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command encoding (from registered fields only)
  // ---------------------------------------------------------------------------
  logic [DW/8-1:0] store_mask;
  logic [DW-1:0]   store_data;

  always_comb begin
    store_mask = 4'b1111;
    store_data = wdata_q;
    if (size_q == SZ_BYTE) begin
      store_mask = 4'b0001 << addr_q[1:0];
      store_data = {4{wdata_q[7:0]}};
    end else if (size_q == SZ_HALF) begin
      store_mask = 4'b0011 << {addr_q[1], 1'b0};
      store_data = {2{wdata_q[15:0]}};
    end
  end

  logic in_cmd;
  assign in_cmd = (state_q == CMD);

  // Command fields are zeroed outside CMD so the bus is quiet while idle.
  assign lsu2dtcm_cmd_valid = in_cmd;
  assign lsu2dtcm_cmd_read  = in_cmd & read_q;
  assign lsu2dtcm_cmd_addr  = in_cmd ? {addr_q[DTCM_AW-1:2], 2'b00} : '0;
  assign lsu2dtcm_cmd_wmask = (in_cmd && !read_q) ? store_mask : '0;
  assign lsu2dtcm_cmd_wdata = in_cmd ? store_data : '0;

  assign lsu2dtcm_rsp_ready = (state_q == RSP);
  assign agu_req_ready      = (state_q == IDLE);

  assign lsu_wb_valid = (state_q == WB);
  assign lsu_wb_data  = wb_data_q;
  assign lsu_wb_rd    = rd_q;

endmodule

// File: tb/tb_lsu_dtcm_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_dtcm_master
//
// Self-checking bench for lsu_dtcm_master. A behavioural model computes the
// expected DTCM command and writeback result from the load/store rules; the
// bench plays both the AGU and the DTCM, with directed scenarios followed by
// randomized transactions with random backpressure.
// -----------------------------------------------------------------------------
module tb_lsu_dtcm_master;

  localparam int DTCM_AW = 16;
  localparam int DW      = 32;

  logic               clk = 1'b0;
  logic               rst_n;

  logic               agu_req_valid;
  logic               agu_req_ready;
  logic               agu_req_read;
  logic [31:0]        agu_req_addr;
  logic [1:0]         agu_req_size;
  logic               agu_req_usign;
  logic [31:0]        agu_req_wdata;
  logic [4:0]         agu_req_rd;

  logic               lsu_wb_valid;
  logic               lsu_wb_ready;
  logic [31:0]        lsu_wb_data;
  logic [4:0]         lsu_wb_rd;
  logic               lsu_wb_err;

  logic               lsu2dtcm_cmd_valid;
  logic               lsu2dtcm_cmd_ready;
  logic               lsu2dtcm_cmd_read;
  logic [DTCM_AW-1:0] lsu2dtcm_cmd_addr;
  logic [3:0]         lsu2dtcm_cmd_wmask;
  logic [31:0]        lsu2dtcm_cmd_wdata;

  logic               lsu2dtcm_rsp_valid;
  logic               lsu2dtcm_rsp_ready;
  logic [31:0]        lsu2dtcm_rsp_rdata;

  int checks = 0;
  int errors = 0;

  lsu_dtcm_master #(.DTCM_AW(DTCM_AW), .DW(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .agu_req_valid      (agu_req_valid),
    .agu_req_ready      (agu_req_ready),
    .agu_req_read       (agu_req_read),
    .agu_req_addr       (agu_req_addr),
    .agu_req_size       (agu_req_size),
    .agu_req_usign      (agu_req_usign),
    .agu_req_wdata      (agu_req_wdata),
    .agu_req_rd         (agu_req_rd),
    .lsu_wb_valid       (lsu_wb_valid),
    .lsu_wb_ready       (lsu_wb_ready),
    .lsu_wb_data        (lsu_wb_data),
    .lsu_wb_rd          (lsu_wb_rd),
    .lsu_wb_err         (lsu_wb_err),
    .lsu2dtcm_cmd_valid (lsu2dtcm_cmd_valid),
    .lsu2dtcm_cmd_ready (lsu2dtcm_cmd_ready),
    .lsu2dtcm_cmd_read  (lsu2dtcm_cmd_read),
    .lsu2dtcm_cmd_addr  (lsu2dtcm_cmd_addr),
    .lsu2dtcm_cmd_wmask (lsu2dtcm_cmd_wmask),
    .lsu2dtcm_cmd_wdata (lsu2dtcm_cmd_wdata),
    .lsu2dtcm_rsp_valid (lsu2dtcm_rsp_valid),
    .lsu2dtcm_rsp_ready (lsu2dtcm_rsp_ready),
    .lsu2dtcm_rsp_rdata (lsu2dtcm_rsp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
`ifdef LSU_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  function automatic int access_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
    return (addr % access_bytes(size)) != 0;
  endfunction

  // Byte address the access really targets (misaligned bits dropped when the
  // checker is absent).
  function automatic int model_eff_addr(input logic [31:0] addr, input logic [1:0] size);
    int a = addr % 65536;
    int n = access_bytes(size);
    return a - (a % n);
  endfunction

  function automatic logic [3:0] model_mask(input int eff, input logic [1:0] size);
    int n = access_bytes(size);
    int off = eff % 4;
    int m = 0;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + n) m += (1 << b);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] size);
    if (size == 2'b00) return (wd % 256) * 32'h0101_0101;
    if (size == 2'b01) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int eff,
                                             input logic [1:0] size, input bit usign);
    int n = access_bytes(size);
    longint v;
    longint lim;
    if (n == 4) return rdata;
    v   = (longint'(rdata) >> (8 * (eff % 4))) % (longint'(1) << (8 * n));
    lim = longint'(1) << (8 * n - 1);
    if (!usign && v >= lim) v = v - 2 * lim;
    return 32'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Generic transaction driver/checker
  // ---------------------------------------------------------------------------
  task automatic run_txn(input bit rd_op, input logic [31:0] addr, input logic [1:0] size,
                         input bit usign, input logic [31:0] wd, input logic [4:0] tag,
                         input logic [31:0] rdata, input int cd, input int rsp_dly,
                         input int wb_dly, input string name);
    bit                 exp_err  = CHK_EN && model_misaligned(addr, size);
    int                 eff      = model_eff_addr(addr, size);
    logic [DTCM_AW-1:0] exp_addr = DTCM_AW'(eff - (eff % 4));
    logic [3:0]         exp_mask = rd_op ? 4'b0000 : model_mask(eff, size);
    logic [31:0]        exp_wd   = model_wdata(wd, size);
    logic [31:0]        exp_data = (rd_op && !exp_err) ? model_load(rdata, eff, size, usign) : 32'h0;

    @(negedge clk);
    checks++;
    if (agu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", name, agu_req_ready);
    end
    agu_req_valid = 1'b1;
    agu_req_read  = rd_op;
    agu_req_addr  = addr;
    agu_req_size  = size;
    agu_req_usign = usign;
    agu_req_wdata = wd;
    agu_req_rd    = tag;
    @(negedge clk);
    agu_req_valid = 1'b0;
    agu_req_wdata = $urandom;
    agu_req_addr  = $urandom;

    if (!exp_err) begin
      for (int i = 0; i <= cd; i++) begin
        lsu2dtcm_cmd_ready = (i == cd);
        lsu2dtcm_rsp_valid = (i == cd) ? 1'b0 : 1'($urandom % 2);
        checks++;
        if ({lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask,
             agu_req_ready, lsu_wb_valid} !== {1'b1, rd_op, exp_addr, exp_mask, 2'b00}) begin
          errors++;
          $display("FAIL %s cmd: got v=%b rd=%b addr=%h mask=%b rdy=%b wbv=%b want v=1 rd=%b addr=%h mask=%b rdy=0 wbv=0",
                   name, lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr,
                   lsu2dtcm_cmd_wmask, agu_req_ready, lsu_wb_valid, rd_op, exp_addr, exp_mask);
        end
        if (!rd_op) begin
          checks++;
          if (lsu2dtcm_cmd_wdata !== exp_wd) begin
            errors++;
            $display("FAIL %s cmd_wdata: got %h want %h", name, lsu2dtcm_cmd_wdata, exp_wd);
          end
        end
        @(negedge clk);
      end
      lsu2dtcm_cmd_ready = 1'b0;
      lsu2dtcm_rsp_valid = 1'b0;

      for (int i = 0; i <= rsp_dly; i++) begin
        checks++;
        if ({lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu_wb_valid, agu_req_ready} !== 4'b1000) begin
          errors++;
          $display("FAIL %s rsp_wait: got rsp_rdy=%b cmd_v=%b wb_v=%b req_rdy=%b want 1 0 0 0",
                   name, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu_wb_valid, agu_req_ready);
        end
        lsu2dtcm_rsp_valid = (i == rsp_dly);
        lsu2dtcm_rsp_rdata = (i == rsp_dly) ? rdata : $urandom;
        lsu2dtcm_cmd_ready = (i == rsp_dly) ? 1'b0 : 1'($urandom % 2);
        @(negedge clk);
      end
      lsu2dtcm_rsp_valid = 1'b0;
      lsu2dtcm_cmd_ready = 1'b0;
      lsu2dtcm_rsp_rdata = $urandom;
    end

    for (int i = 0; i <= wb_dly; i++) begin
      lsu_wb_ready = (i == wb_dly);
      checks++;
      if ({lsu_wb_valid, lsu_wb_data, lsu_wb_rd, lsu_wb_err, agu_req_ready, lsu2dtcm_cmd_valid}
          !== {1'b1, exp_data, tag, exp_err, 2'b00}) begin
        errors++;
        $display("FAIL %s wb: got v=%b data=%h rd=%0d err=%b req_rdy=%b cmd_v=%b want v=1 data=%h rd=%0d err=%b req_rdy=0 cmd_v=0",
                 name, lsu_wb_valid, lsu_wb_data, lsu_wb_rd, lsu_wb_err, agu_req_ready,
                 lsu2dtcm_cmd_valid, exp_data, tag, exp_err);
      end
      @(negedge clk);
    end
    lsu_wb_ready = 1'b0;
    checks++;
    if ({agu_req_ready, lsu_wb_valid} !== 2'b10) begin
      errors++;
      $display("FAIL %s post_wb: got req_rdy=%b wb_v=%b want 1 0", name, agu_req_ready, lsu_wb_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n              = 1'b0;
    agu_req_valid      = 1'b0;
    agu_req_read       = 1'b0;
    agu_req_addr       = '0;
    agu_req_size       = 2'b00;
    agu_req_usign      = 1'b0;
    agu_req_wdata      = '0;
    agu_req_rd         = '0;
    lsu_wb_ready       = 1'b0;
    lsu2dtcm_cmd_ready = 1'b0;
    lsu2dtcm_rsp_valid = 1'b0;
    lsu2dtcm_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({agu_req_ready, lsu_wb_valid, lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_read,
         lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata, lsu_wb_data, lsu_wb_rd, lsu_wb_err}
        !== {1'b1, 4'b0, 16'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got req_rdy=%b wb_v=%b cmd_v=%b rsp_rdy=%b addr=%h mask=%b wd=%h wbd=%h rd=%0d err=%b want idle/zero",
               agu_req_ready, lsu_wb_valid, lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_addr,
               lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata, lsu_wb_data, lsu_wb_rd, lsu_wb_err);
    end
  endtask

  task automatic test_word_store();
    run_txn(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 5'd3, 32'h1357_9BDF, 0, 0, 0, "word_store");
  endtask

  task automatic test_byte_load();
    run_txn(1'b1, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 5'd7, 32'h8011_2233, 0, 0, 0, "byte_load_s");
    run_txn(1'b1, 32'h0000_0103, 2'b00, 1'b1, 32'h0, 5'd8, 32'h8011_2233, 0, 0, 0, "byte_load_u");
    run_txn(1'b1, 32'h0000_0202, 2'b01, 1'b0, 32'h0, 5'd9, 32'h9ABC_1234, 0, 0, 0, "half_load_s");
  endtask

  task automatic test_half_store();
    run_txn(1'b0, 32'h0000_0002, 2'b01, 1'b0, 32'h1234_ABCD, 5'd11, 32'h0, 0, 0, 0, "half_store");
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 32'h0000_0311, 2'b00, 1'b0, 32'h0, 5'd21, 32'h55AA_F00D, 3, 2, 2, "backpressure");
  endtask

  task automatic test_misalign();
    run_txn(1'b1, 32'h0000_0006, 2'b10, 1'b0, 32'h0, 5'd17, 32'hCAFE_F00D, 0, 0, 0, "misalign_word");
    run_txn(1'b0, 32'h0000_0045, 2'b01, 1'b0, 32'h0000_BEEF, 5'd18, 32'h0, 1, 0, 1, "misalign_half");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    agu_req_valid = 1'b1;
    agu_req_read  = 1'b1;
    agu_req_addr  = 32'h0000_0040;
    agu_req_size  = 2'b10;
    agu_req_rd    = 5'd30;
    @(negedge clk);
    agu_req_valid      = 1'b0;
    lsu2dtcm_cmd_ready = 1'b1;
    @(negedge clk);
    lsu2dtcm_cmd_ready = 1'b0;
    checks++;
    if (lsu2dtcm_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid in_rsp: got rsp_rdy=%b want 1", lsu2dtcm_rsp_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({agu_req_ready, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu_wb_valid, lsu_wb_rd, lsu_wb_data}
        !== {4'b1000, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid idle: got req_rdy=%b rsp_rdy=%b cmd_v=%b wb_v=%b rd=%0d data=%h want 1 0 0 0 0 0",
               agu_req_ready, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu_wb_valid, lsu_wb_rd, lsu_wb_data);
    end
    lsu2dtcm_rsp_valid = 1'b1;
    lsu2dtcm_rsp_rdata = 32'hFFFF_FFFF;
    lsu2dtcm_cmd_ready = 1'b1;
    @(negedge clk);
    lsu2dtcm_rsp_valid = 1'b0;
    lsu2dtcm_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({lsu_wb_valid, agu_req_ready, lsu2dtcm_cmd_valid} !== 3'b010) begin
        errors++;
        $display("FAIL reset_mid stray_rsp: got wb_v=%b req_rdy=%b cmd_v=%b want 0 1 0",
                 lsu_wb_valid, agu_req_ready, lsu2dtcm_cmd_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom % 2), $urandom, 2'($urandom % 4), 1'($urandom % 2), $urandom,
              5'($urandom % 32), $urandom, int'($urandom % 3), int'($urandom % 3),
              int'($urandom % 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dtcm_master.md
Name: lsu_dtcm_master

Overview:
- LSU-side initiator for the DTCM command/response interface; it drives lsu2dtcm_cmd_* and consumes lsu2dtcm_rsp_*.
- Accepts one load/store request from the EXU AGU.
- Converts the request into a word-aligned DTCM command with a byte write mask and lane-replicated write data.
- Returns sign- or zero-extended load data, or a store completion, on a writeback handshake.
- Only one transaction is outstanding at a time.

Parameters:
- DTCM_AW, 16: DTCM byte-address width. The command address is `agu_req_addr[DTCM_AW-1:0]`.
- DW, 32: data width. Fixed at 32. The mask width is DW/8 = 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- agu_req_valid  in  1  request valid
- agu_req_ready  out  1  request ready
- agu_req_read  in  1  1 = load, 0 = store
- agu_req_addr  in  32  byte address
- agu_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- agu_req_usign  in  1  1 = zero-extend load data
- agu_req_wdata  in  32  store data, right-aligned
- agu_req_rd  in  5  destination register tag
- lsu_wb_valid  out  1  completion valid
- lsu_wb_ready  in  1  completion ready
- lsu_wb_data  out  32  formatted load data; 0 for stores
- lsu_wb_rd  out  5  tag of the completed request
- lsu_wb_err  out  1  misaligned-access error
- lsu2dtcm_cmd_valid  out  1  command valid
- lsu2dtcm_cmd_ready  in  1  command ready
- lsu2dtcm_cmd_read  out  1  1 = read
- lsu2dtcm_cmd_addr  out  DTCM_AW  byte address, bits [1:0] forced to 0
- lsu2dtcm_cmd_wmask  out  4  byte write enables; 0 on reads
- lsu2dtcm_cmd_wdata  out  32  lane-replicated write data
- lsu2dtcm_rsp_valid  in  1  response valid
- lsu2dtcm_rsp_ready  out  1  response ready
- lsu2dtcm_rsp_rdata  in  32  response data

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset: state = IDLE, and all registered request fields are cleared.
  - Outputs at reset: agu_req_ready = 1, all other valid/ready outputs = 0, cmd_* = 0, lsu_wb_data = 0, lsu_wb_rd = 0, lsu_wb_err = 0.
- Reset mid-operation: returns to IDLE next edge. Any in-flight command or response is abandoned, and no writeback is issued.
- State machine: states IDLE, CMD, RSP, WB.
  - IDLE: agu_req_ready = 1. On agu_req_valid, register read, addr, size, usign, wdata and rd, then go to CMD.
  - CMD: cmd_valid = 1 with cmd fields driven from registers only. Stay in CMD until cmd_ready; then go to RSP.
  - RSP: rsp_ready = 1. On rsp_valid, capture the formatted result into the wb_data register and go to WB.
  - WB: lsu_wb_valid = 1. Hold data, rd and err stable until lsu_wb_ready; then go to IDLE.
- Handshake: agu_req_ready is asserted only in IDLE, so there are no back-to-back requests. Minimum request-to-wb_valid latency is 3 cycles, reached when cmd_ready = 1 and rsp_valid arrives the cycle after the command is accepted.
- Stray inputs: rsp_valid outside RSP is ignored, and cmd_ready outside CMD is ignored.
- Write mask (stores):
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: shift rdata right by 8 × addr[1:0] for bytes, or by 16 × addr[1] for halves.
  - Sign-extend from bit 7 or bit 15 when usign = 0; zero-extend when usign = 1.
  - Word loads pass rdata through unchanged.
- Stores: lsu_wb_data = 0. The DTCM response is still awaited before completion.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] ≠ 0; handling is defined under Optional Feature.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: a misaligned request goes from IDLE directly to WB with lsu_wb_err = 1 and lsu_wb_data = 0. No DTCM command is issued.
- Undefined: lsu_wb_err is tied to 0.
  - Misaligned address low bits are cleared: bit 0 for halves, bits [1:0] for words.
  - The access then proceeds normally as an aligned access.

Test Plan:
- Word store 0xDEADBEEF to addr 0x0100 with cmd_ready = 1: cmd_valid rises the cycle after acceptance with addr = 0x0100, wmask = 4'b1111, read = 0. After rsp_valid, wb_valid = 1 with wb_data = 0.
- Byte load, addr 0x0103, usign = 0, rdata = 0x80112233: wb_data = 0xFFFFFF80. The same request with usign = 1 gives wb_data = 0x00000080.
- Half store 0x1234ABCD to addr 0x0002: wmask = 4'b1100, wdata = 0xABCDABCD.
- Backpressure: cmd_ready held 0 for 3 cycles, then rsp_valid delayed 2 cycles, then wb_ready held 0 for 2 cycles.
  - cmd fields and wb_data/rd stay stable throughout.
  - agu_req_ready stays 0 until the WB handshake completes.
- Word load from addr 0x0006:
  - With LSU_MISALIGN_CHK_EN: no cmd_valid is seen; wb_err = 1 and wb_data = 0 the cycle after acceptance.
  - Without the macro: cmd addr = 0x0004 and wb_err = 0.
- rst_n driven low while in RSP: the next cycle shows IDLE outputs with agu_req_ready = 1. A later rsp_valid pulse produces no wb_valid.
